ifid_fetch_queue: RTL

- Consumer side of the fetch stage's instruction/PC output interface: buffers fetched {instr, PC} pairs and hands them to the decode stage.
- Uses a valid/ready handshake on both sides, so fetch keeps running while decode stalls, up to DEPTH entries.
- Sits between the fetch stage and the decode stage of the 5-stage MIPS pipeline; replaces a plain IF/ID register.
- Flush discards wrong-path instructions on a taken branch/jump.

---
 rtl/ifid_fetch_queue.sv | 81 ++++++++
 1 files changed

// File: rtl/ifid_fetch_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer of {instr, pc} pairs between fetch and decode.
// Latency: one cycle from push to head visibility (show-ahead head, no input-to-output bypass).
// Backpressure: in_ready drops only on full (registered state); flush empties the queue and drops any same-cycle push.
module ifid_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PTR_W     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;

    // in_ready looks only at the occupancy register, so a full queue refuses
    // a push even when decode pops in the same cycle.
    assign in_ready  = (cnt != CNT_FULL);
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign out_instr = out_valid ? mem[rp].instr : NOP_INSTR;
    assign out_pc    = out_valid ? mem[rp].pc    : RESET_PC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Storage carries no reset; only entries between rp and wp are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= '{instr: in_instr, pc: in_pc};
        end
    end

endmodule
